// File: rtl/mig_eval_pkg.sv
// Shared parameters, types and source-read helpers for the
// time-multiplexed MIG evaluator.
package mig_eval_pkg;

  localparam int NUM_IN    = 4;
  localparam int MAX_NODES = 8;
  localparam int SEL_W     = 4;
  localparam int OP_W      = 5;
  localparam int CNT_W     = 4;
  localparam int ADDR_W    = 3;

  localparam int SRC_CONST0 = 0;
  localparam int SRC_X0     = 1;
  localparam int SRC_NODE0  = NUM_IN + 1;
  localparam int SRC_LAST   = NUM_IN + MAX_NODES;

  typedef enum logic [1:0] {
    IDLE,
    EVAL,
    DONE
  } state_t;

  typedef struct packed {
    logic             inv;
    logic [SEL_W-1:0] sel;
  } operand_t;

  typedef struct packed {
    operand_t c;
    operand_t b;
    operand_t a;
  } node_op_t;

  typedef struct packed {
    logic bad;
    logic val;
  } src_t;

  // Nodes at index >= lim are not yet evaluated and read as illegal.
  function automatic src_t src_read(
    input logic [SEL_W-1:0]     sel,
    input logic [NUM_IN-1:0]    xv,
    input logic [MAX_NODES-1:0] nv,
    input logic [CNT_W-1:0]     lim
  );
    int   s;
    src_t r;
    s = int'(sel);
    r = '{bad: 1'b0, val: 1'b0};
    if (s == SRC_CONST0) begin
      r.val = 1'b0;
    end else if (s > SRC_LAST) begin
      r.bad = 1'b1;
    end else begin
      for (int i = 0; i < NUM_IN; i++) begin
        if (s == SRC_X0 + i) r.val = xv[i];
      end
      for (int j = 0; j < MAX_NODES; j++) begin
        if (s == SRC_NODE0 + j) begin
          if (j < int'(lim)) r.val = nv[j];
          else r.bad = 1'b1;
        end
      end
    end
    return r;
  endfunction

  function automatic logic maj3(
    input logic p,
    input logic q,
    input logic r
  );
    return (p & q) | (p & r) | (q & r);
  endfunction

endpackage

// File: rtl/mig_maj3_unit.sv
// Shared majority-3 datapath: three operand muxes, optional
// complement per operand, MAJ3, and per-operand legality.
import mig_eval_pkg::*;

module mig_maj3_unit (
  input  node_op_t             op,
  input  logic [NUM_IN-1:0]    x,
  input  logic [MAX_NODES-1:0] nodes,
  input  logic [CNT_W-1:0]     k,
  output logic                 v,
  output logic                 bad
);

  src_t sa;
  src_t sb;
  src_t sc;
  logic pa;
  logic pb;
  logic pc;

  always_comb begin
    sa  = src_read(op.a.sel, x, nodes, k);
    sb  = src_read(op.b.sel, x, nodes, k);
    sc  = src_read(op.c.sel, x, nodes, k);
    pa  = sa.val ^ op.a.inv;
    pb  = sb.val ^ op.b.inv;
    pc  = sc.val ^ op.c.inv;
    v   = maj3(pa, pb, pc);
    bad = sa.bad | sb.bad | sc.bad;
  end

endmodule

// File: rtl/mig_seq_evaluator.sv
// Evaluates a loadable MIG program one node per cycle on a
// single shared MAJ3 unit, then presents y until consumed.
import mig_eval_pkg::*;

module mig_seq_evaluator (
  input  logic                clk,
  input  logic                rst,
  input  logic                prog_we,
  input  logic [ADDR_W-1:0]   prog_addr,
  input  logic [3*OP_W-1:0]   prog_data,
  input  logic [CNT_W-1:0]    num_nodes,
  input  logic [SEL_W-1:0]    out_sel,
  input  logic                out_inv,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [NUM_IN-1:0]   x,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                y,
  output logic                err,
  output logic                busy
);

  state_t               state;
  node_op_t             mem [MAX_NODES];
  logic [MAX_NODES-1:0] nodes;
  logic [NUM_IN-1:0]    x_lat;
  logic [CNT_W-1:0]     nn;
  logic [CNT_W-1:0]     k;
  logic [SEL_W-1:0]     osel;
  logic                 oinv;

  logic                 nn_over;
  logic [CNT_W-1:0]     nn_clamp;
  logic                 v;
  logic                 v_bad;
  src_t                 osrc;

  assign nn_over  = num_nodes > CNT_W'(MAX_NODES);
  assign nn_clamp = nn_over ? CNT_W'(MAX_NODES) : num_nodes;

  assign in_ready  = state == IDLE;
  assign out_valid = state == DONE;
  assign busy      = state != IDLE;

  mig_maj3_unit u_maj (
    .op    (mem[k[ADDR_W-1:0]]),
    .x     (x_lat),
    .nodes (nodes),
    .k     (k),
    .v     (v),
    .bad   (v_bad)
  );

  always_comb begin
    osrc = src_read(osel, x_lat, nodes, nn);
  end

  // One extra EVAL step at k==nn resolves y from settled node regs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      nodes <= '0;
      x_lat <= '0;
      nn    <= '0;
      k     <= '0;
      osel  <= '0;
      oinv  <= 1'b0;
      y     <= 1'b0;
      err   <= 1'b0;
      for (int i = 0; i < MAX_NODES; i++) begin
        mem[i] <= '0;
      end
    end else begin
      unique case (state)
        IDLE: begin
          if (prog_we) begin
            mem[prog_addr] <= node_op_t'(prog_data);
          end
          if (in_valid) begin
            x_lat <= x;
            nn    <= nn_clamp;
            osel  <= out_sel;
            oinv  <= out_inv;
            nodes <= '0;
            k     <= '0;
            err   <= nn_over;
            state <= EVAL;
          end
        end
        EVAL: begin
          if (k < nn) begin
            nodes[k[ADDR_W-1:0]] <= v;
            err                  <= err | v_bad;
            k                    <= k + CNT_W'(1);
          end else begin
            y     <= osrc.val ^ oinv;
            err   <= err | osrc.bad;
            state <= DONE;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
